// File: rtl/l2cache_core.sv
// rtl/l2cache_core.sv - 4-way 8-set write-back L2 cache core with tree PLRU and memory master port
module l2cache_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_cyc,
  input  logic         cpu_stb,
  input  logic         cpu_we,
  input  logic [11:0]  cpu_adr,
  input  logic [15:0]  cpu_sel,
  input  logic [127:0] cpu_dat_i,
  output logic [127:0] cpu_dat_o,
  output logic         cpu_ack,
  output logic         mem_cyc,
  output logic         mem_stb,
  output logic         mem_we,
  output logic [11:0]  mem_adr,
  output logic [127:0] mem_dat_o,
  input  logic [127:0] mem_dat_i,
  input  logic         mem_ack,
  input  logic         mem_rty
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FETCH} state_t;

  state_t        state, state_nxt;
  logic [11:0]   mar_adr;
  logic          mar_we;
  logic [15:0]   mar_sel;
  logic [127:0]  mar_dat;

  // Arrays are flattened as {way, index}.
  logic [127:0]  data_mem [0:31];
  logic [8:0]    tag_mem  [0:31];
  logic [31:0]   valid, dirty;
  logic [2:0]    plru [0:7];  // bit0 = b0, bit1 = b1, bit2 = b2

  logic [2:0]    idx;
  logic [8:0]    tag;
  logic          hit;
  logic [1:0]    hit_way, victim, victim_q;
  logic [127:0]  hit_data, merged;
  logic          miss_dirty;

  function automatic logic [4:0] slot(input logic [1:0] way, input logic [2:0] set);
    return {way, set};
  endfunction

  assign idx = mar_adr[2:0];
  assign tag = mar_adr[11:3];

  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (valid[slot(2'(w), idx)] && tag_mem[slot(2'(w), idx)] == tag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  assign hit_data = data_mem[slot(hit_way, idx)];

  always_comb begin
    merged = hit_data;
    for (int i = 0; i < 16; i++) begin
      if (mar_sel[i]) merged[8*i +: 8] = mar_dat[8*i +: 8];
    end
  end

  // Descending scan so the lowest-numbered invalid way wins over the PLRU choice.
  always_comb begin
    if (plru[idx][0]) victim = plru[idx][2] ? 2'd3 : 2'd2;
    else              victim = plru[idx][1] ? 2'd1 : 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (!valid[slot(2'(w), idx)]) victim = 2'(w);
    end
  end

  assign miss_dirty = valid[slot(victim, idx)] && dirty[slot(victim, idx)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mar_adr  <= '0;
      mar_we   <= 1'b0;
      mar_sel  <= '0;
      mar_dat  <= '0;
      victim_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_cyc && cpu_stb) begin
        mar_adr <= cpu_adr;
        mar_we  <= cpu_we;
        mar_sel <= cpu_sel;
        mar_dat <= cpu_dat_i;
      end
      if (state == CHECK && !hit) victim_q <= victim;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cpu_cyc && cpu_stb) state_nxt = CHECK;
      CHECK:     if (hit) state_nxt = IDLE;
                 else     state_nxt = miss_dirty ? WRITEBACK : FETCH;
      WRITEBACK: if (mem_ack) state_nxt = FETCH;
      FETCH:     if (mem_ack) state_nxt = CHECK;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_ack   = 1'b0;
    cpu_dat_o = '0;
    mem_cyc   = 1'b0;
    mem_stb   = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_dat_o = '0;
    case (state)
      CHECK: if (hit) begin
        cpu_ack   = 1'b1;
        cpu_dat_o = hit_data;
      end
      WRITEBACK: begin
        mem_cyc   = 1'b1;
        mem_stb   = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = {tag_mem[slot(victim_q, idx)], idx};
        mem_dat_o = data_mem[slot(victim_q, idx)];
      end
      FETCH: begin
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        mem_adr = mar_adr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
      for (int s = 0; s < 8; s++) plru[s] <= 3'b000;
    end else begin
      if (state == CHECK && hit) begin
        if (hit_way[1]) begin
          plru[idx][0] <= 1'b0;
          plru[idx][2] <= ~hit_way[0];
        end else begin
          plru[idx][0] <= 1'b1;
          plru[idx][1] <= ~hit_way[0];
        end
        if (mar_we) dirty[slot(hit_way, idx)] <= 1'b1;
      end
      if (state == FETCH && mem_ack) begin
        valid[slot(victim_q, idx)] <= 1'b1;
        dirty[slot(victim_q, idx)] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CHECK && hit && mar_we) data_mem[slot(hit_way, idx)] <= merged;
    if (state == FETCH && mem_ack) begin
      data_mem[slot(victim_q, idx)] <= mem_dat_i;
      tag_mem[slot(victim_q, idx)]  <= tag;
    end
  end

endmodule

// File: tb/tb_l2cache_core.sv
// tb/tb_l2cache_core.sv - directed table-driven bench for l2cache_core with a line-memory model
module tb_l2cache_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_cyc, cpu_stb, cpu_we;
  logic [11:0]  cpu_adr;
  logic [15:0]  cpu_sel;
  logic [127:0] cpu_dat_i, cpu_dat_o;
  logic         cpu_ack;
  logic         mem_cyc, mem_stb, mem_we;
  logic [11:0]  mem_adr;
  logic [127:0] mem_dat_o, mem_dat_i;
  logic         mem_ack, mem_rty;

  l2cache_core dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_sel(cpu_sel), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack(cpu_ack),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack(mem_ack), .mem_rty(mem_rty)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] P000 = 128'hCAFE0000_CAFE0000_CAFE0000_CAFE0000;
  localparam logic [127:0] P008 = 128'hCAFE0008_CAFE0008_CAFE0008_CAFE0008;
  localparam logic [127:0] P010 = 128'hCAFE0010_CAFE0010_CAFE0010_CAFE0010;
  localparam logic [127:0] P012 = 128'hCAFE0012_CAFE0012_CAFE0012_CAFE0012;
  localparam logic [127:0] M012 = 128'hCAFE0012_CAFE0012_CAFE0012_CAFE00AB;
  localparam logic [127:0] P018 = 128'hCAFE0018_CAFE0018_CAFE0018_CAFE0018;
  localparam logic [127:0] P020 = 128'hCAFE0020_CAFE0020_CAFE0020_CAFE0020;
  localparam logic [127:0] P028 = 128'hCAFE0028_CAFE0028_CAFE0028_CAFE0028;
  localparam logic [127:0] P031 = 128'hCAFE0031_CAFE0031_CAFE0031_CAFE0031;
  localparam logic [127:0] P041 = 128'hCAFE0041_CAFE0041_CAFE0041_CAFE0041;
  localparam logic [127:0] D0   = 128'h11112222_33334444_55556666_77778888;

  typedef struct {
    logic         we;
    logic [11:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    int           lat;
    int           exp_cyc;
    logic         exp_wb;
    logic [11:0]  exp_wb_adr;
    logic [127:0] exp_wb_dat;
    logic         exp_fetch;
    logic [11:0]  exp_fetch_adr;
    logic [127:0] exp_data;
  } vec_t;

  vec_t         vq[$];
  logic [127:0] mem_model [0:4095];
  int           errors = 0;
  int           checks = 0;

  logic [127:0] r_data;
  int           r_cyc;
  logic         r_wb, r_fetch, r_timeout;
  logic [11:0]  r_wb_adr, r_fetch_adr;
  logic [127:0] r_wb_dat;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and act as the memory slave until cpu_ack or the cycle budget runs out.
  task automatic run_req(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                         input logic [127:0] dat, input int lat, input int rty);
    int w;
    int rl;
    w = 0;
    rl = rty;
    r_data = '0; r_cyc = 0; r_wb = 0; r_wb_adr = '0; r_wb_dat = '0;
    r_fetch = 0; r_fetch_adr = '0; r_timeout = 1;
    cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_adr = adr; cpu_sel = sel; cpu_dat_i = dat;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 0;
        w = 0;
      end
      mem_rty = 0;
      if (cpu_ack) begin
        r_data = cpu_dat_o;
        r_cyc = c;
        r_timeout = 0;
        break;
      end
      if (mem_cyc && mem_stb) begin
        if (mem_we) begin
          if (!r_wb) begin
            r_wb = 1; r_wb_adr = mem_adr; r_wb_dat = mem_dat_o;
          end
        end else if (!r_fetch) begin
          r_fetch = 1; r_fetch_adr = mem_adr;
        end
        if (rl > 0 && !mem_we) begin
          chk("rty_hold_adr", {116'd0, mem_adr}, {116'd0, adr});
          rl--;
          mem_rty = 1;
        end else begin
          w++;
          if (w >= lat) begin
            mem_ack = 1;
            if (mem_we) mem_model[mem_adr] = mem_dat_o;
            else        mem_dat_i = mem_model[mem_adr];
          end
        end
      end
    end
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0;
    mem_ack = 0; mem_rty = 0;
    chk("req_done", {127'd0, r_timeout}, 128'd0);
    if (!r_timeout) begin
      @(posedge clk); #1;
      chk("ack_one_cycle", {127'd0, cpu_ack}, 128'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = {4{20'hCAFE0, 12'(i)}};
    rst_n = 0;
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_adr = '0; cpu_sel = '0; cpu_dat_i = '0;
    mem_dat_i = '0; mem_ack = 0; mem_rty = 0;

    //            we  adr     sel      dat     lat cyc wb adr     wbdat fe adr     data
    vq.push_back('{0, 12'h012, 16'h0000, 128'h0,  3, 5, 0, 12'h000, 128'h0, 1, 12'h012, P012});
    vq.push_back('{0, 12'h012, 16'h0000, 128'h0,  2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P012});
    vq.push_back('{1, 12'h012, 16'h0001, 128'hAB, 2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P012});
    vq.push_back('{0, 12'h012, 16'h0000, 128'h0,  2, 1, 0, 12'h000, 128'h0, 0, 12'h000, M012});
    vq.push_back('{0, 12'h000, 16'h0000, 128'h0,  2, 4, 0, 12'h000, 128'h0, 1, 12'h000, P000});
    vq.push_back('{0, 12'h008, 16'h0000, 128'h0,  2, 4, 0, 12'h000, 128'h0, 1, 12'h008, P008});
    vq.push_back('{0, 12'h010, 16'h0000, 128'h0,  2, 4, 0, 12'h000, 128'h0, 1, 12'h010, P010});
    vq.push_back('{0, 12'h018, 16'h0000, 128'h0,  2, 4, 0, 12'h000, 128'h0, 1, 12'h018, P018});
    vq.push_back('{0, 12'h000, 16'h0000, 128'h0,  2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P000});
    vq.push_back('{0, 12'h020, 16'h0000, 128'h0,  2, 4, 0, 12'h000, 128'h0, 1, 12'h020, P020});
    vq.push_back('{0, 12'h010, 16'h0000, 128'h0,  2, 4, 0, 12'h000, 128'h0, 1, 12'h010, P010});
    vq.push_back('{0, 12'h000, 16'h0000, 128'h0,  2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P000});
    vq.push_back('{0, 12'h018, 16'h0000, 128'h0,  2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P018});
    vq.push_back('{1, 12'h000, 16'hFFFF, D0,      2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P000});
    vq.push_back('{0, 12'h010, 16'h0000, 128'h0,  2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P010});
    vq.push_back('{0, 12'h020, 16'h0000, 128'h0,  2, 1, 0, 12'h000, 128'h0, 0, 12'h000, P020});
    vq.push_back('{0, 12'h028, 16'h0000, 128'h0,  2, 6, 1, 12'h000, D0,     1, 12'h028, P028});
    vq.push_back('{0, 12'h000, 16'h0000, 128'h0,  2, 4, 0, 12'h000, 128'h0, 1, 12'h000, D0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ack", {127'd0, cpu_ack}, 128'd0);
    chk("rst_cpu_dat_o", cpu_dat_o, 128'd0);
    chk("rst_mem_ctl", {125'd0, mem_cyc, mem_stb, mem_we}, 128'd0);
    chk("rst_mem_adr", {116'd0, mem_adr}, 128'd0);
    chk("rst_mem_dat_o", mem_dat_o, 128'd0);
    rst_n = 1;

    foreach (vq[i]) begin
      run_req(vq[i].we, vq[i].adr, vq[i].sel, vq[i].dat, vq[i].lat, 0);
      chk($sformatf("v%0d_cycles", i), 128'(r_cyc), 128'(vq[i].exp_cyc));
      chk($sformatf("v%0d_wb", i), {127'd0, r_wb}, {127'd0, vq[i].exp_wb});
      if (vq[i].exp_wb) begin
        chk($sformatf("v%0d_wb_adr", i), {116'd0, r_wb_adr}, {116'd0, vq[i].exp_wb_adr});
        chk($sformatf("v%0d_wb_dat", i), r_wb_dat, vq[i].exp_wb_dat);
      end
      chk($sformatf("v%0d_fetch", i), {127'd0, r_fetch}, {127'd0, vq[i].exp_fetch});
      if (vq[i].exp_fetch)
        chk($sformatf("v%0d_fetch_adr", i), {116'd0, r_fetch_adr}, {116'd0, vq[i].exp_fetch_adr});
      chk($sformatf("v%0d_data", i), r_data, vq[i].exp_data);
    end

    // Retry held for four cycles during FETCH.
    run_req(0, 12'h031, 16'h0000, 128'h0, 1, 4);
    chk("rty_cycles", 128'(r_cyc), 128'd7);
    chk("rty_fetch_adr", {116'd0, r_fetch_adr}, {116'd0, 12'h031});
    chk("rty_data", r_data, P031);

    // Reset asserted while a fill is outstanding.
    cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_adr = 12'h041; cpu_sel = '0; cpu_dat_i = '0;
    r_fetch = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (mem_cyc && !mem_we) begin
        r_fetch = 1;
        break;
      end
    end
    chk("rstmid_fetch_seen", {127'd0, r_fetch}, 128'd1);
    #2 rst_n = 0;
    #1;
    chk("rstmid_mem_ctl", {125'd0, mem_cyc, mem_stb, mem_we}, 128'd0);
    chk("rstmid_mem_adr", {116'd0, mem_adr}, 128'd0);
    chk("rstmid_cpu_ack", {127'd0, cpu_ack}, 128'd0);
    cpu_cyc = 0; cpu_stb = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    run_req(0, 12'h041, 16'h0000, 128'h0, 2, 0);
    chk("post_rst_041_cycles", 128'(r_cyc), 128'd4);
    chk("post_rst_041_fetch", {127'd0, r_fetch}, 128'd1);
    chk("post_rst_041_data", r_data, P041);
    run_req(0, 12'h012, 16'h0000, 128'h0, 2, 0);
    chk("post_rst_012_fetch", {127'd0, r_fetch}, 128'd1);
    chk("post_rst_012_wb", {127'd0, r_wb}, 128'd0);
    chk("post_rst_012_data", r_data, P012);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
